// File: rtl/cache_pkg.sv
// Shared state encoding, memory opcodes and width helpers
// for the parametrised set-associative data cache.
package cache_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_WAIT,
    S_RF_REQ,
    S_RF_WAIT,
    S_RESP,
    S_FL_SCAN,
    S_FL_WB_REQ,
    S_FL_WB_WAIT
  } state_t;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WB = 1'b1;

  function automatic int off_w(int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(int addr_w, int sets, int line_bytes);
    return addr_w - $clog2(sets) - $clog2(line_bytes);
  endfunction

  // A direct-mapped cache still needs a one-bit way field.
  function automatic int way_w(int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/param_sa_cache_if.sv
// CPU, memory and flush signals of the data cache.
// slave = cache side, master = CPU/memory side.
interface param_sa_cache_if #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W-1:0]       req_addr;
  logic                    req_we;
  logic [DATA_W-1:0]       req_wdata;
  logic [DATA_W/8-1:0]     req_wstrb;
  logic                    resp_valid;
  logic [DATA_W-1:0]       resp_rdata;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_we;
  logic [ADDR_W-1:0]       mem_req_addr;
  logic [8*LINE_BYTES-1:0] mem_wdata;
  logic                    mem_resp_valid;
  logic [8*LINE_BYTES-1:0] mem_rdata;
  logic                    flush;
  logic                    flush_done;

  modport slave (
    input  req_valid, req_addr, req_we,
    input  req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata,
    output mem_req_valid, mem_req_we,
    output mem_req_addr, mem_wdata,
    input  mem_req_ready, mem_resp_valid,
    input  mem_rdata, flush,
    output flush_done
  );

  modport master (
    output req_valid, req_addr, req_we,
    output req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req_valid, mem_req_we,
    input  mem_req_addr, mem_wdata,
    output mem_req_ready, mem_resp_valid,
    output mem_rdata, flush,
    input  flush_done
  );

endinterface

// File: rtl/cache_tag_array.sv
// Valid/dirty/tag/round-robin storage per set with parallel
// tag compare, victim selection and fill/dirty/invalidate ports.
module cache_tag_array
  import cache_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 256,
  parameter  int TAG_W = 50,
  localparam int IDX_W = idx_w(SETS),
  localparam int WAY_W = way_w(WAYS)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] cmp_tag,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic [WAY_W-1:0] vict_way,
  input  logic [WAY_W-1:0] sel_way,
  output logic             sel_valid,
  output logic             sel_dirty,
  output logic [TAG_W-1:0] sel_tag,
  input  logic [WAY_W-1:0] wr_way,
  input  logic             fill_en,
  input  logic             fill_dirty,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             dirty_en,
  input  logic             inval_en
);

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAY_W-1:0] ptr_q   [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAY_W-1:0] ptr_nxt;

  // Descending scans so the lowest matching/invalid way wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    vict_way = ptr_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == cmp_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w])
        vict_way = WAY_W'(w);
    end
  end

  assign sel_valid = valid_q[idx][sel_way];
  assign sel_dirty = dirty_q[idx][sel_way];
  assign sel_tag   = tag_q[idx][sel_way];

  assign ptr_nxt = (ptr_q[idx] == WAY_W'(WAYS - 1)) ?
                   '0 : ptr_q[idx] + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      if (fill_en) begin
        valid_q[idx][wr_way] <= 1'b1;
        dirty_q[idx][wr_way] <= fill_dirty;
        ptr_q[idx]           <= ptr_nxt;
      end
      if (dirty_en)
        dirty_q[idx][wr_way] <= 1'b1;
      if (inval_en) begin
        valid_q[idx][wr_way] <= 1'b0;
        dirty_q[idx][wr_way] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en)
      tag_q[idx][wr_way] <= fill_tag;
  end

endmodule

// File: rtl/param_sa_cache.sv
// Set-associative write-back, write-allocate data cache with
// miss FSM, byte strobes and full-cache flush.
module param_sa_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int WAYS       = 4,
  parameter int SETS       = 256,
  parameter int LINE_BYTES = 64
)(
  input logic             clk,
  input logic             rst,
  param_sa_cache_if.slave bus
);

  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_BYTES);
  localparam int WAY_W  = way_w(WAYS);
  localparam int NB     = DATA_W / 8;
  localparam int BS     = $clog2(NB);

  state_t state;

  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [OFF_W-1:0]  wsel_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic [WAY_W-1:0]  vict_q;
  logic [IDX_W-1:0]  fl_set_q, fl_set_nxt;
  logic [WAY_W-1:0]  fl_way_q, fl_way_nxt;
  logic              fl_last;
  logic              mreq_v_q, mreq_we_q;
  logic [ADDR_W-1:0] mreq_addr_q;
  logic [LINE_W-1:0] mreq_wd_q;
  logic [DATA_W-1:0] rdata_q;
  logic              fl_done_q;

  logic [LINE_W-1:0] data_q [SETS*WAYS];

  logic              scan, hit, sel_valid, sel_dirty;
  logic              fill_en, dirty_en;
  logic [IDX_W-1:0]  t_idx;
  logic [WAY_W-1:0]  hit_way, vict_way, sel_way, rd_way, wr_way;
  logic [TAG_W-1:0]  sel_tag;
  logic [LINE_W-1:0] line_rd, fill_line;
  logic [DATA_W-1:0] hit_word, hit_mrg, fill_mrg;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] wd,
    input logic [NB-1:0]     st
  );
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++)
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic int lidx(
    input logic [IDX_W-1:0] s,
    input logic [WAY_W-1:0] w
  );
    return int'(s) * WAYS + int'(w);
  endfunction

  // The flush walk borrows the tag array's read/invalidate port.
  assign scan    = (state == S_FL_SCAN);
  assign t_idx   = scan ? fl_set_q : idx_q;
  assign sel_way = scan ? fl_way_q : vict_way;
  assign rd_way  = (hit && !scan) ? hit_way : sel_way;
  assign wr_way  = (state == S_LOOKUP) ? hit_way :
                   scan ? fl_way_q : vict_q;

  assign fill_en  = (state == S_RF_WAIT) && bus.mem_resp_valid;
  assign dirty_en = (state == S_LOOKUP) && hit && we_q;

  cache_tag_array #(
    .WAYS (WAYS),
    .SETS (SETS),
    .TAG_W(TAG_W)
  ) u_tags (
    .clk       (clk),
    .rst       (rst),
    .idx       (t_idx),
    .cmp_tag   (tag_q),
    .hit       (hit),
    .hit_way   (hit_way),
    .vict_way  (vict_way),
    .sel_way   (sel_way),
    .sel_valid (sel_valid),
    .sel_dirty (sel_dirty),
    .sel_tag   (sel_tag),
    .wr_way    (wr_way),
    .fill_en   (fill_en),
    .fill_dirty(we_q),
    .fill_tag  (tag_q),
    .dirty_en  (dirty_en),
    .inval_en  (scan)
  );

  assign line_rd  = data_q[lidx(t_idx, rd_way)];
  assign hit_word = line_rd[wsel_q*DATA_W +: DATA_W];
  assign hit_mrg  = we_q ? merge(hit_word, wdata_q, wstrb_q)
                         : hit_word;
  assign fill_mrg = we_q ?
    merge(bus.mem_rdata[wsel_q*DATA_W +: DATA_W], wdata_q, wstrb_q) :
    bus.mem_rdata[wsel_q*DATA_W +: DATA_W];

  always_comb begin
    fill_line = bus.mem_rdata;
    fill_line[wsel_q*DATA_W +: DATA_W] = fill_mrg;
  end

  assign fl_last = (fl_set_q == IDX_W'(SETS - 1)) &&
                   (fl_way_q == WAY_W'(WAYS - 1));

  always_comb begin
    fl_way_nxt = fl_way_q + 1'b1;
    fl_set_nxt = fl_set_q;
    if (fl_way_q == WAY_W'(WAYS - 1)) begin
      fl_way_nxt = '0;
      fl_set_nxt = fl_set_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (dirty_en)
      data_q[lidx(idx_q, hit_way)][wsel_q*DATA_W +: DATA_W] <= hit_mrg;
    if (fill_en)
      data_q[lidx(idx_q, vict_q)] <= fill_line;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tag_q       <= '0;
      idx_q       <= '0;
      wsel_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      vict_q      <= '0;
      fl_set_q    <= '0;
      fl_way_q    <= '0;
      mreq_v_q    <= 1'b0;
      mreq_we_q   <= MEM_RD;
      mreq_addr_q <= '0;
      mreq_wd_q   <= '0;
      rdata_q     <= '0;
      fl_done_q   <= 1'b0;
    end else begin
      fl_done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.flush) begin
            fl_set_q <= '0;
            fl_way_q <= '0;
            state    <= S_FL_SCAN;
          end else if (bus.req_valid) begin
            tag_q   <= bus.req_addr[ADDR_W-1 -: TAG_W];
            idx_q   <= bus.req_addr[OFF_W +: IDX_W];
            wsel_q  <= bus.req_addr[OFF_W-1:0] >> BS;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            state <= S_IDLE;
          end else begin
            vict_q   <= vict_way;
            mreq_v_q <= 1'b1;
            if (sel_valid && sel_dirty) begin
              mreq_we_q   <= MEM_WB;
              mreq_addr_q <= {sel_tag, idx_q, {OFF_W{1'b0}}};
              mreq_wd_q   <= line_rd;
              state       <= S_WB_REQ;
            end else begin
              mreq_we_q   <= MEM_RD;
              mreq_addr_q <= {tag_q, idx_q, {OFF_W{1'b0}}};
              state       <= S_RF_REQ;
            end
          end
        end
        S_WB_REQ: begin
          if (bus.mem_req_ready) begin
            mreq_v_q <= 1'b0;
            state    <= S_WB_WAIT;
          end
        end
        S_WB_WAIT: begin
          if (bus.mem_resp_valid) begin
            mreq_v_q    <= 1'b1;
            mreq_we_q   <= MEM_RD;
            mreq_addr_q <= {tag_q, idx_q, {OFF_W{1'b0}}};
            state       <= S_RF_REQ;
          end
        end
        S_RF_REQ: begin
          if (bus.mem_req_ready) begin
            mreq_v_q <= 1'b0;
            state    <= S_RF_WAIT;
          end
        end
        S_RF_WAIT: begin
          if (bus.mem_resp_valid) begin
            rdata_q <= fill_mrg;
            state   <= S_RESP;
          end
        end
        S_RESP: state <= S_IDLE;
        S_FL_SCAN: begin
          if (sel_valid && sel_dirty) begin
            mreq_v_q    <= 1'b1;
            mreq_we_q   <= MEM_WB;
            mreq_addr_q <= {sel_tag, fl_set_q, {OFF_W{1'b0}}};
            mreq_wd_q   <= line_rd;
            state       <= S_FL_WB_REQ;
          end else if (fl_last) begin
            fl_done_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            fl_set_q <= fl_set_nxt;
            fl_way_q <= fl_way_nxt;
          end
        end
        S_FL_WB_REQ: begin
          if (bus.mem_req_ready) begin
            mreq_v_q <= 1'b0;
            state    <= S_FL_WB_WAIT;
          end
        end
        S_FL_WB_WAIT: begin
          if (bus.mem_resp_valid) begin
            if (fl_last) begin
              fl_done_q <= 1'b1;
              state     <= S_IDLE;
            end else begin
              fl_set_q <= fl_set_nxt;
              fl_way_q <= fl_way_nxt;
              state    <= S_FL_SCAN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state == S_IDLE) && !bus.flush && !rst;
  assign bus.resp_valid    = ((state == S_LOOKUP) && hit) ||
                             (state == S_RESP);
  assign bus.resp_rdata    = (state == S_LOOKUP) ? hit_mrg : rdata_q;
  assign bus.mem_req_valid = mreq_v_q;
  assign bus.mem_req_we    = mreq_we_q;
  assign bus.mem_req_addr  = mreq_addr_q;
  assign bus.mem_wdata     = mreq_wd_q;
  assign bus.flush_done    = fl_done_q;

endmodule

// File: tb/tb_param_sa_cache.sv
// Directed bench for param_sa_cache: hits, misses, eviction
// writeback, flush and asynchronous reset aborts.
module tb_param_sa_cache;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_sa_cache_if bus ();

  param_sa_cache dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic stall = 1'b0;
  logic mem_off = 1'b0;

  logic [511:0] mem_lines [logic [63:0]];
  logic         log_we   [$];
  logic [63:0]  log_addr [$];
  logic [511:0] log_wd   [$];

  task automatic chk(input string tag, input logic [511:0] o,
                     input logic [511:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic log_clear();
    log_we.delete();
    log_addr.delete();
    log_wd.delete();
  endtask

  // Line memory: holds ready low one cycle, then answers.
  initial begin
    logic         r_we;
    logic [63:0]  r_addr;
    logic [511:0] r_wd;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    forever begin
      @(negedge clk);
      if (!mem_off && !rst && bus.mem_req_valid) begin
        r_we   = bus.mem_req_we;
        r_addr = bus.mem_req_addr;
        r_wd   = bus.mem_wdata;
        @(negedge clk);
        chk("mem_hold_stable",
            {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr},
            {1'b1, r_we, r_addr});
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        log_we.push_back(r_we);
        log_addr.push_back(r_addr);
        log_wd.push_back(r_wd);
        if (r_we) mem_lines[r_addr] = r_wd;
        @(negedge clk);
        if (!stall) begin
          bus.mem_rdata = '0;
          if (!r_we && mem_lines.exists(r_addr))
            bus.mem_rdata = mem_lines[r_addr];
          bus.mem_resp_valid = 1'b1;
          @(negedge clk);
          bus.mem_resp_valid = 1'b0;
        end
      end
    end
  end

  task automatic cpu_req(input logic [63:0] a, input logic w,
                         input logic [63:0] wd, input logic [7:0] st,
                         output logic [63:0] rd, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_we    = w;
    bus.req_wdata = wd;
    bus.req_wstrb = st;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.resp_rdata;
  endtask

  initial begin
    logic [63:0]  rd;
    logic [511:0] el;
    int lat, n, dn, rb;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.flush     = 1'b0;
    el = '0;
    el[63:0] = 64'hDEADBEEF00000001;
    mem_lines[64'h1000] = el;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_flush_done", bus.flush_done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", bus.req_ready, 1);

    // Cold miss on 0x1000.
    log_clear();
    cpu_req(64'h1000, 0, '0, '0, rd, lat);
    chk("miss1_rdata", rd, 64'hDEADBEEF00000001);
    chk("miss1_nreq", log_addr.size(), 1);
    chk("miss1_we", log_we[0], 0);
    chk("miss1_addr", log_addr[0], 64'h1000);

    // Hit: one cycle after acceptance, no memory traffic.
    log_clear();
    cpu_req(64'h1000, 0, '0, '0, rd, lat);
    chk("hit_lat", lat, 1);
    chk("hit_rdata", rd, 64'hDEADBEEF00000001);
    chk("hit_nreq", log_addr.size(), 0);

    cpu_req(64'h1000, 1, 64'h1122334455667788, 8'h0F, rd, lat);
    chk("wr_hit_lat", lat, 1);
    chk("wr_hit_merged", rd, 64'hDEADBEEF55667788);
    cpu_req(64'h1000, 0, '0, '0, rd, lat);
    chk("rd_after_wr", rd, 64'hDEADBEEF55667788);
    chk("wr_nreq", log_addr.size(), 0);

    // Fill the other three ways of set 0x40.
    cpu_req(64'h5000, 0, '0, '0, rd, lat);
    cpu_req(64'h9000, 0, '0, '0, rd, lat);
    cpu_req(64'hD000, 0, '0, '0, rd, lat);
    chk("fill3_nreq", log_addr.size(), 3);
    chk("fill3_no_wb", {log_we[0], log_we[1], log_we[2]}, 0);

    // Round-robin victim is way 0, the dirty 0x1000 line.
    log_clear();
    el = '0;
    el[63:0] = 64'hDEADBEEF55667788;
    cpu_req(64'h11000, 0, '0, '0, rd, lat);
    chk("evict_nreq", log_addr.size(), 2);
    chk("evict_wb_we", log_we[0], 1);
    chk("evict_wb_addr", log_addr[0], 64'h1000);
    chk("evict_wb_line", log_wd[0], el);
    chk("evict_rf_we", log_we[1], 0);
    chk("evict_rf_addr", log_addr[1], 64'h11000);
    chk("evict_rdata", rd, 0);

    // Dirty lines in sets 1 and 2.
    cpu_req(64'h40, 1, 64'h0123456789ABCDEF, 8'hFF, rd, lat);
    chk("set1_wr", rd, 64'h0123456789ABCDEF);
    cpu_req(64'h80, 1, 64'hCAFEF00D12345678, 8'hF0, rd, lat);
    chk("set2_wr", rd, 64'hCAFEF00D00000000);

    log_clear();
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    n = 0; dn = 0; rb = 0;
    while (dn == 0 && n < 5000) begin
      if (bus.flush_done) dn++;
      else if (bus.req_ready) rb++;
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      if (bus.flush_done) dn++;
      @(negedge clk);
    end
    chk("flush_done_once", dn, 1);
    chk("flush_ready_low", rb, 0);
    chk("flush_nwb", log_addr.size(), 2);
    chk("flush_wb0", {log_we[0], log_addr[0]}, {1'b1, 64'h40});
    chk("flush_wb1", {log_we[1], log_addr[1]}, {1'b1, 64'h80});
    chk("flush_wb0_word", log_wd[0][63:0], 64'h0123456789ABCDEF);

    log_clear();
    cpu_req(64'h40, 0, '0, '0, rd, lat);
    chk("post_flush_miss1", log_addr.size(), 1);
    chk("post_flush_rd1", rd, 64'h0123456789ABCDEF);
    cpu_req(64'h80, 0, '0, '0, rd, lat);
    chk("post_flush_miss2", log_addr.size(), 2);
    chk("post_flush_rd2", rd, 64'hCAFEF00D00000000);

    // Re-cache 0x1000, then reset during a refill wait.
    cpu_req(64'h1000, 0, '0, '0, rd, lat);
    chk("recache_rd", rd, 64'hDEADBEEF55667788);
    cpu_req(64'h1000, 0, '0, '0, rd, lat);
    chk("recache_hit_lat", lat, 1);

    log_clear();
    stall = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h2000;
    bus.req_we    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (log_addr.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rfw_accepted", log_addr.size(), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rfw_rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rfw_rst_req_ready", bus.req_ready, 0);
    chk("rfw_rst_resp_valid", bus.resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("rfw_rel_ready", bus.req_ready, 1);

    log_clear();
    cpu_req(64'h1000, 0, '0, '0, rd, lat);
    chk("rst_lost_miss", log_addr.size(), 1);
    chk("rst_lost_fetch", {log_we[0], log_addr[0]}, {1'b0, 64'h1000});
    chk("rst_lost_rd", rd, 64'hDEADBEEF55667788);

    // Reset while a fetch request is still being offered.
    mem_off = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h3000;
    bus.req_we    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.mem_req_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rfq_valid", bus.mem_req_valid, 1);
    chk("rfq_addr", bus.mem_req_addr, 64'h3000);
    rst = 1'b1;
    #1;
    chk("rfq_rst_drop", bus.mem_req_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_off = 1'b0;
    @(negedge clk);
    chk("rfq_rel_ready", bus.req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
